debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 144 ++++++++++++++
 rtl/debounce_multi.sv | 43 ++++
 tb/tb_debounce_multi.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
// Build option: define DEBOUNCE_AUTOREPEAT_EN to add per-channel hold auto-repeat.
package debounce_pkg;

  // 50 us of stability at a 20 ns clock
  localparam int DELAY_COUNTS_50US = 2500;

  // Bits needed to hold the values 0..n inclusive
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, saturating stability counter,
// debounced level with press/release pulses, and optional hold auto-repeat.
// Build option: DEBOUNCE_AUTOREPEAT_EN enables the hold counter and repeat_o.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DELAY_COUNTS  = DELAY_COUNTS_50US,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  if (DELAY_COUNTS < 1) begin : g_bad_delay
    $error("debounce_channel: DELAY_COUNTS must be >= 1");
  end

  localparam int              CNT_W   = cnt_width(DELAY_COUNTS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY_COUNTS);
  localparam logic            INV     = (ACTIVE_LOW != 0);

  logic             sync1_q, sync2_q;
  logic             s;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  // Synchroniser; flops reset to the raw idle level so the polarity-corrected
  // output starts inactive for either polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= INV;
      sync2_q <= INV;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ INV;

  // Stability counter restarts on any change of s and saturates at DELAY_COUNTS;
  // a saturated, still-stable input commits its level on the following edge.
  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s != prev_q) begin
      prev_d = s;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d   = prev_q;
      press_d = prev_q & ~lvl_q;
      rel_d   = ~prev_q & lvl_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter, level and edge-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign pressed_o = lvl_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int            RW        = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD);

  logic [RW-1:0] hold_q, hold_d, hold_inc;
  logic          first_q, first_d;
  logic          rep_q, rep_d;

  // Hold counter: cleared by a press, runs while held, reloads after each
  // repeat; the cycle that commits a release never produces a repeat.
  always_comb begin
    hold_d   = hold_q;
    first_d  = first_q;
    rep_d    = 1'b0;
    hold_inc = hold_q + RW'(1);
    if (press_d) begin
      hold_d  = '0;
      first_d = 1'b1;
    end else if (lvl_q && !rel_d) begin
      if (hold_inc == (first_q ? REP_FIRST : REP_NEXT)) begin
        rep_d   = 1'b1;
        hold_d  = '0;
        first_d = 1'b0;
      end else begin
        hold_d = hold_inc;
      end
    end else begin
      hold_d = '0;
    end
  end

  // Hold counter and repeat pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      first_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      first_q <= first_d;
      rep_q   <= rep_d;
    end
  end

  assign repeat_o = rep_q;
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = (REPEAT_DELAY == REPEAT_PERIOD);
  assign repeat_o       = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel pushbutton debouncer: independent channels, each with its own
// synchroniser, stability counter, level and press/release pulses.
// Build option: DEBOUNCE_AUTOREPEAT_EN adds hold auto-repeat on repeat_pulse.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DELAY_COUNTS  = DELAY_COUNTS_50US,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] button_pressed,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  if (N_CH < 1) begin : g_bad_nch
    $error("debounce_multi: N_CH must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DELAY_COUNTS (DELAY_COUNTS),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .button_i (button[i]),
      .pressed_o(button_pressed[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i]),
      .repeat_o (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (N_CH=4, DELAY_COUNTS=8, REPEAT 20/6).
`timescale 1ns/1ps
module tb_debounce_multi;

  localparam int N   = 4;
  localparam int DC  = 8;
  localparam int RD  = 20;
  localparam int RP  = 6;
  localparam int LAT = DC + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] button;
  logic [N-1:0] button_pressed, press_pulse, release_pulse, repeat_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int both_total = 0;

  int press_cnt[N], rel_cnt[N], press_at[N], rel_at[N], rise_at[N], fall_at[N];
  int rep0[$];
  logic [N-1:0] prev_lvl;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH         (N),
    .DELAY_COUNTS (DC),
    .ACTIVE_LOW   (0),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button        (button),
    .button_pressed(button_pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0;
      press_at[i] = -1; rel_at[i] = -1; rise_at[i] = -1; fall_at[i] = -1;
    end
    rep0.delete();
    prev_lvl = button_pressed;
  endtask

  // One clock: sample outputs 1 ns after the rising edge and log events
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (press_pulse[i])   begin press_cnt[i]++; press_at[i] = cyc; end
      if (release_pulse[i]) begin rel_cnt[i]++;   rel_at[i]   = cyc; end
      if (press_pulse[i] && release_pulse[i]) both_total++;
      if (button_pressed[i] && !prev_lvl[i]) rise_at[i] = cyc;
      if (!button_pressed[i] && prev_lvl[i]) fall_at[i] = cyc;
    end
    if (repeat_pulse[0]) rep0.push_back(cyc);
    prev_lvl = button_pressed;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  int t0, tp, n_early, n_after;
  int tr[N];

  initial begin
    rst    = 1'b1;
    button = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level",   button_pressed, 4'b0000);
    chk("reset_press",   press_pulse,    4'b0000);
    chk("reset_release", release_pulse,  4'b0000);
    chk("reset_repeat",  repeat_pulse,   4'b0000);
    rst = 1'b0;
    clr();

    // 1: single press on channel 0
    button[0] = 1'b1;
    t0 = cyc + 1;
    run(20);
    chk("t1_level0",     button_pressed[0], 1'b1);
    chk("t1_rise_time",  rise_at[0], t0 + LAT);
    chk("t1_press_cnt",  press_cnt[0], 1);
    chk("t1_press_time", press_at[0], t0 + LAT);
    chk("t1_others",     button_pressed[3:1], 3'b000);
    chk("t1_oth_press",  press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // 2: channel 1 bounces before settling high
    clr();
    button[1] = 1'b1; run(3);
    button[1] = 1'b0; run(3);
    button[1] = 1'b1; run(3);
    button[1] = 1'b0; run(3);
    button[1] = 1'b1;
    t0 = cyc + 1;
    run(20);
    chk("t2_rise_time", rise_at[1], t0 + LAT);
    chk("t2_press_cnt", press_cnt[1], 1);
    chk("t2_rel_cnt",   rel_cnt[1], 0);
    chk("t2_ch0_quiet", press_cnt[0], 0);

    // 3: channel 2 held, then a 5-cycle low glitch
    button[2] = 1'b1;
    run(15);
    clr();
    button[2] = 1'b0; run(5);
    button[2] = 1'b1; run(20);
    chk("t3_level2",    button_pressed[2], 1'b1);
    chk("t3_rel_cnt",   rel_cnt[2], 0);
    chk("t3_press_cnt", press_cnt[2], 0);

    // 4: all pressed together, released in order 3,1,0,2
    button = '0;
    run(20);
    chk("t4_idle", button_pressed, 4'b0000);
    clr();
    button = 4'b1111;
    t0 = cyc + 1;
    run(15);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t4_press_cnt%0d", i),  press_cnt[i], 1);
      chk($sformatf("t4_press_time%0d", i), press_at[i], t0 + LAT);
    end
    button[3] = 1'b0; tr[3] = cyc + 1; run(2);
    button[1] = 1'b0; tr[1] = cyc + 1; run(2);
    button[0] = 1'b0; tr[0] = cyc + 1; run(2);
    button[2] = 1'b0; tr[2] = cyc + 1; run(20);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t4_rel_cnt%0d", i),  rel_cnt[i], 1);
      chk($sformatf("t4_rel_time%0d", i), rel_at[i], tr[i] + LAT);
    end

    // 5: async reset while channel 3 is mid-count and channel 0 is pressed
    clr();
    button = 4'b0001;
    run(15);
    chk("t5_pre_level0", button_pressed[0], 1'b1);
    button = 4'b1001;
    run(8);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_level",  button_pressed, 4'b0000);
    chk("t5_rst_pulses", press_pulse | release_pulse | repeat_pulse, 4'b0000);
    #1 rst = 1'b0;
    clr();
    t0 = cyc + 1;
    run(15);
    chk("t5_rise0",   rise_at[0], t0 + LAT);
    chk("t5_rise3",   rise_at[3], t0 + LAT);
    chk("t5_press3",  press_cnt[3], 1);

    // 6: channel 0 held 50 cycles past qualification, then released
    button = '0;
    run(20);
    clr();
    button[0] = 1'b1;
    t0 = cyc + 1;
    tp = t0 + LAT;
    run(62);
    button[0] = 1'b0;
    run(20);
    chk("t6_fall_time", fall_at[0], tp + 50 + 1 + LAT);
    n_early = 0;
    n_after = 0;
    foreach (rep0[k]) begin
      if (rep0[k] <= tp + 50) n_early++;
      if (rep0[k] >= fall_at[0]) n_after++;
    end
`ifdef DEBOUNCE_AUTOREPEAT_EN
    chk("t6_rep_in_50", n_early, 6);
    chk("t6_rep_total", rep0.size(), 7);
    chk("t6_rep_after", n_after, 0);
    for (int k = 0; k < 6; k++) begin
      if (k < rep0.size()) chk($sformatf("t6_rep%0d", k), rep0[k], tp + RD + RP * k);
      else                 chk($sformatf("t6_rep%0d", k), 0, tp + RD + RP * k);
    end
`else
    chk("t6_rep_total", rep0.size(), 0);
`endif

    chk("never_both_pulses", both_total, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
